// File: rtl/shift_reg_bank_pkg.sv
// Shared constants for the shift_reg_bank register bank: operating mode encodings.
package shift_reg_bank_pkg;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

endpackage : shift_reg_bank_pkg

// File: rtl/shift_reg_bank_reg_stage.sv
// One storage stage of the bank: a WIDTH-bit flop with async active-low reset
// that captures its next value only when its load enable is high.
module reg_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Stage register: cleared by reset, otherwise updated only on load enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : reg_stage

// File: rtl/shift_reg_bank.sv
// Parametrised multi-stage register bank with hold/shift/rotate/parallel-load
// modes, synchronous clear, clock enable and a saturating occupancy counter.
// All outputs are derived from registered state only.
module shift_reg_bank
    import shift_reg_bank_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       din,
    input  logic [WIDTH*DEPTH-1:0] pdin,
    output logic [WIDTH*DEPTH-1:0] q,
    output logic [WIDTH*DEPTH-1:0] q_n,
    output logic [WIDTH-1:0]       dout,
    output logic [CW-1:0]          count,
    output logic                   full
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic             stage_ld;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // All stages move together: clear forces a write of zero, otherwise any
    // enabled non-hold mode writes every stage.
    assign stage_ld = clr | (en & (mode != MODE_HOLD));

    // Next-value mux for every stage; clear dominates, then the selected mode.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
        end else begin
            case (mode)
                MODE_SHIFT: begin
                    stage_d[0] = din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
                MODE_ROT: begin
                    stage_d[0] = stage_q[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
                MODE_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_d[i] = pdin[i*WIDTH +: WIDTH];
                    end
                end
                default: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i];
                    end
                end
            endcase
        end
    end

    // Occupancy: clear empties, shift fills by one and saturates, load fills,
    // rotate and hold leave it alone.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            case (mode)
                MODE_SHIFT: begin
                    if (count_q != DEPTH_C) begin
                        count_d = count_q + 1'b1;
                    end
                end
                MODE_LOAD: count_d = DEPTH_C;
                default:   count_d = count_q;
            endcase
        end
    end

    // Occupancy counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            reg_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .ld_i  (stage_ld),
                .d_i   (stage_d[g]),
                .q_o   (stage_q[g])
            );
            assign q[g*WIDTH +: WIDTH] = stage_q[g];
        end
    endgenerate

    assign q_n   = ~q;
    assign dout  = stage_q[DEPTH-1];
    assign count = count_q;
    assign full  = (count_q == DEPTH_C);

endmodule : shift_reg_bank

// File: tb/tb_shift_reg_bank.sv
// Directed self-checking bench for shift_reg_bank with WIDTH=4, DEPTH=4.
module tb_shift_reg_bank;
    import shift_reg_bank_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                   clk;
    logic                   rst_n;
    logic                   en;
    logic                   clr;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       din;
    logic [WIDTH*DEPTH-1:0] pdin;
    logic [WIDTH*DEPTH-1:0] q;
    logic [WIDTH*DEPTH-1:0] q_n;
    logic [WIDTH-1:0]       dout;
    logic [CW-1:0]          count;
    logic                   full;

    int vectors;
    int miscompares;

    shift_reg_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .mode  (mode),
        .din   (din),
        .pdin  (pdin),
        .q     (q),
        .q_n   (q_n),
        .dout  (dout),
        .count (count),
        .full  (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = MODE_HOLD;
        din = '0; pdin = '0;
        #2;
        vectors++;
        if (q !== 16'h0000) begin miscompares++; $display("FAIL reset_q_async got=%h want=0000", q); end
        tick(); tick();
        vectors++;
        if (q !== 16'h0000) begin miscompares++; $display("FAIL reset_q got=%h want=0000", q); end
        vectors++;
        if (q_n !== 16'hFFFF) begin miscompares++; $display("FAIL reset_qn got=%h want=FFFF", q_n); end
        vectors++;
        if (dout !== 4'h0) begin miscompares++; $display("FAIL reset_dout got=%h want=0", dout); end
        vectors++;
        if (count !== 3'd0 || full !== 1'b0) begin
            miscompares++; $display("FAIL reset_count got=%0d/%b want=0/0", count, full);
        end
        rst_n = 1'b1; en = 1'b0; mode = MODE_SHIFT; din = 4'hF;
        tick();
        vectors++;
        if (q !== 16'h0000 || count !== 3'd0) begin
            miscompares++; $display("FAIL reset_release_en0 got=%h/%0d want=0000/0", q, count);
        end
    endtask

    task automatic test_shift_fill();
        logic [3:0] seq [4];
        logic [2:0] cexp [4];
        logic [15:0] qexp [4];
        seq  = '{4'h1, 4'h2, 4'h3, 4'h4};
        cexp = '{3'd1, 3'd2, 3'd3, 3'd4};
        qexp = '{16'h0001, 16'h0012, 16'h0123, 16'h1234};
        en = 1'b1; mode = MODE_SHIFT;
        for (int i = 0; i < 4; i++) begin
            din = seq[i];
            tick();
            // change din between edges: must not be seen
            din = 4'hE;
            vectors++;
            if (q !== qexp[i] || count !== cexp[i]) begin
                miscompares++;
                $display("FAIL shift_fill_%0d got=%h/%0d want=%h/%0d", i, q, count, qexp[i], cexp[i]);
            end
        end
        vectors++;
        if (dout !== 4'h1 || full !== 1'b1) begin
            miscompares++; $display("FAIL shift_fill_dout_full got=%h/%b want=1/1", dout, full);
        end
        din = 4'h5;
        tick();
        vectors++;
        if (q !== 16'h2345 || count !== 3'd4 || full !== 1'b1) begin
            miscompares++; $display("FAIL shift_saturate got=%h/%0d/%b want=2345/4/1", q, count, full);
        end
        vectors++;
        if (dout !== 4'h2) begin miscompares++; $display("FAIL shift_saturate_dout got=%h want=2", dout); end
    endtask

    task automatic test_enable_gating();
        en = 1'b0; mode = MODE_SHIFT; din = 4'hF;
        tick(); tick(); tick();
        vectors++;
        if (q !== 16'h2345 || count !== 3'd4) begin
            miscompares++; $display("FAIL enable_hold got=%h/%0d want=2345/4", q, count);
        end
        en = 1'b1; mode = MODE_ROT;
        tick();
        vectors++;
        if (q !== 16'h3452 || count !== 3'd4) begin
            miscompares++; $display("FAIL rotate_full got=%h/%0d want=3452/4", q, count);
        end
        mode = MODE_HOLD; din = 4'hA;
        tick();
        vectors++;
        if (q !== 16'h3452 || count !== 3'd4) begin
            miscompares++; $display("FAIL mode_hold got=%h/%0d want=3452/4", q, count);
        end
    endtask

    task automatic test_load_clear();
        en = 1'b1; mode = MODE_LOAD; pdin = 16'hA5C3;
        tick();
        vectors++;
        if (q !== 16'hA5C3 || count !== 3'd4) begin
            miscompares++; $display("FAIL load got=%h/%0d want=A5C3/4", q, count);
        end
        vectors++;
        if (q_n !== 16'h5A3C || dout !== 4'hA || full !== 1'b1) begin
            miscompares++; $display("FAIL load_derived got=%h/%h/%b want=5A3C/A/1", q_n, dout, full);
        end
        clr = 1'b1; en = 1'b0; mode = MODE_LOAD; pdin = 16'hFFFF;
        tick();
        vectors++;
        if (q !== 16'h0000 || count !== 3'd0 || full !== 1'b0) begin
            miscompares++; $display("FAIL clear_priority got=%h/%0d/%b want=0000/0/0", q, count, full);
        end
        clr = 1'b1; en = 1'b1; mode = MODE_LOAD; pdin = 16'h1111;
        tick();
        vectors++;
        if (q !== 16'h0000 || count !== 3'd0) begin
            miscompares++; $display("FAIL clear_over_load got=%h/%0d want=0000/0", q, count);
        end
        clr = 1'b0;
    endtask

    task automatic test_partial_rotate();
        en = 1'b1; mode = MODE_SHIFT; din = 4'h7;
        tick(); tick();
        vectors++;
        if (q !== 16'h0077 || count !== 3'd2 || full !== 1'b0) begin
            miscompares++; $display("FAIL partial_fill got=%h/%0d/%b want=0077/2/0", q, count, full);
        end
        mode = MODE_ROT;
        tick();
        vectors++;
        if (q !== 16'h0770 || count !== 3'd2) begin
            miscompares++; $display("FAIL partial_rotate got=%h/%0d want=0770/2", q, count);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; mode = MODE_SHIFT; din = 4'h3;
        tick();
        vectors++;
        if (q !== 16'h7703 || count !== 3'd3) begin
            miscompares++; $display("FAIL pre_async got=%h/%0d want=7703/3", q, count);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (q !== 16'h0000 || count !== 3'd0 || q_n !== 16'hFFFF) begin
            miscompares++; $display("FAIL async_assert got=%h/%0d want=0000/0", q, count);
        end
        din = 4'h8;
        tick();
        vectors++;
        if (q !== 16'h0000 || count !== 3'd0) begin
            miscompares++; $display("FAIL async_clock_ignored got=%h/%0d want=0000/0", q, count);
        end
        @(negedge clk);
        rst_n = 1'b1; din = 4'h9;
        tick();
        vectors++;
        if (q !== 16'h0009 || count !== 3'd1) begin
            miscompares++; $display("FAIL async_release_shift got=%h/%0d want=0009/1", q, count);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_shift_fill();
        test_enable_gating();
        test_load_clear();
        test_partial_rotate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_shift_reg_bank
